// File: rtl/bp_be_issue_queue.sv
// In-order issue queue: buffers fetched {instr, pc} pairs and releases the head
// only when its source and destination registers are free in the scoreboard.
`timescale 1ns/1ps
module bp_be_issue_queue #(
    parameter int els_p         = 4,
    parameter int vaddr_width_p = 39
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic [31:0]              fe_instr_i,
    input  logic [vaddr_width_p-1:0] fe_pc_i,
    input  logic                     fe_v_i,
    output logic                     fe_ready_o,
    output logic [31:0]              issue_instr_o,
    output logic [vaddr_width_p-1:0] issue_pc_o,
    output logic                     issue_v_o,
    input  logic                     issue_yumi_i,
    input  logic                     wb_v_i,
    input  logic [4:0]               wb_rd_addr_i,
    input  logic                     flush_i
);

    localparam int PTR_W = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int CNT_W = $clog2(els_p + 1);

    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_OP        = 7'b0110011;
    localparam logic [6:0] OP_OP32      = 7'b0111011;
    localparam logic [6:0] OP_OPIMM     = 7'b0010011;
    localparam logic [6:0] OP_OPIMM32   = 7'b0011011;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;
    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;

    logic [31:0]              r_instr_mem [els_p];
    logic [vaddr_width_p-1:0] r_pc_mem    [els_p];
    logic [PTR_W-1:0]         r_rd_ptr;
    logic [PTR_W-1:0]         r_wr_ptr;
    logic [CNT_W-1:0]         r_count;
    logic [31:0]              r_busy;

    logic [31:0]              w_head_instr;
    logic [6:0]               w_opcode;
    logic [4:0]               w_rs1;
    logic [4:0]               w_rs2;
    logic [4:0]               w_rd;
    logic                     w_rs1_used;
    logic                     w_rs2_used;
    logic                     w_rd_used;
    logic                     w_hazard;
    logic                     w_empty;
    logic                     w_enq;
    logic                     w_deq;
    logic [31:0]              w_busy_nxt;

    assign w_head_instr  = r_instr_mem[r_rd_ptr];
    assign w_opcode      = w_head_instr[6:0];
    assign w_rd          = w_head_instr[11:7];
    assign w_rs1         = w_head_instr[19:15];
    assign w_rs2         = w_head_instr[24:20];

    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_rd_used  = 1'b0;
        case (w_opcode)
            OP_LOAD:                  begin w_rs1_used = 1'b1; w_rd_used = 1'b1; end
            OP_STORE, OP_BRANCH:      begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; end
            OP_OP, OP_OP32:           begin w_rs1_used = 1'b1; w_rs2_used = 1'b1; w_rd_used = 1'b1; end
            OP_OPIMM, OP_OPIMM32,
            OP_JALR, OP_SYSTEM:       begin w_rs1_used = 1'b1; w_rd_used = 1'b1; end
            OP_LUI, OP_AUIPC, OP_JAL: w_rd_used = 1'b1;
            default: ;
        endcase
        // x0 is never tracked, so it can never cause a WAW stall or be marked busy
        if (w_rd == 5'd0) w_rd_used = 1'b0;
    end

    assign w_hazard = (w_rs1_used & r_busy[w_rs1])
                    | (w_rs2_used & r_busy[w_rs2])
                    | (w_rd_used  & r_busy[w_rd]);

    assign w_empty       = (r_count == '0);
    assign fe_ready_o    = (r_count != CNT_W'(els_p));
    assign issue_v_o     = ~w_empty & ~w_hazard;
    assign issue_instr_o = w_head_instr;
    assign issue_pc_o    = r_pc_mem[r_rd_ptr];

    assign w_enq = fe_v_i & fe_ready_o & ~flush_i;
    assign w_deq = issue_yumi_i & issue_v_o;

    // Setting is applied after clearing so an issue and a writeback of the same register leave it busy
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_v_i)             w_busy_nxt[wb_rd_addr_i] = 1'b0;
        if (w_deq && w_rd_used) w_busy_nxt[w_rd] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_busy   <= '0;
        end else begin
            r_busy <= w_busy_nxt;
            if (flush_i) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_enq) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_deq) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_enq) begin
            r_instr_mem[r_wr_ptr] <= fe_instr_i;
            r_pc_mem[r_wr_ptr]    <= fe_pc_i;
        end
    end

endmodule
